voltage_stats_block: RTL and testbench

- Parametrised windowed statistics engine for the oscilloscope computation path, and successor to the single-channel fixed-width voltage block.
- Per window of ADC samples it produces max, min, peak-to-peak, sum and sum of squares, for downstream mean/RMS division.
- Windows close on an internal sample count or an external frame strobe (mode port).
- It qualifies input with a sample-valid, saturates with a sticky overflow flag, and publishes a one-cycle result strobe.

---
 rtl/voltage_stats_block.sv | 86 ++++++++
 tb/tb_voltage_stats_block.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/voltage_stats_block.sv
// voltage_stats_block: windowed max/min/peak-to-peak/sum/sum-of-squares engine with saturation and a registered result strobe.
module voltage_stats_block #(
    parameter int DATA_W  = 12,
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 500
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EXT_FRAME,
    input  logic              FRAME_END,
    input  logic              SAMPLE_VALID,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] MAX_VOL,
    output logic [DATA_W-1:0] MIN_VOL,
    output logic [DATA_W-1:0] PK_PK,
    output logic [ACC_W-1:0]  SUM,
    output logic [ACC_W-1:0]  SUM_SQ,
    output logic [CNT_W-1:0]  SAMPLE_CNT,
    output logic              OVF,
    output logic              STATS_VALID
);
    localparam logic [CNT_W-1:0] WIN = CNT_W'(WIN_LEN);
    logic [DATA_W-1:0]   max_q, max_d, min_q, min_d;
    logic [ACC_W-1:0]    sum_q, sum_d, sq_q, sq_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d, close, empty;
    logic [ACC_W:0]      sum_x, sq_x;
    logic [2*DATA_W-1:0] prod;
    // A zero count marks an empty window; running max/min rest at 0 so an empty close publishes zeros.
    always_comb begin
        prod  = {{DATA_W{1'b0}}, DATA_IN} * {{DATA_W{1'b0}}, DATA_IN};
        empty = cnt_q == '0;
        sum_x = {1'b0, sum_q} + {{(ACC_W+1-DATA_W){1'b0}}, DATA_IN};
        sq_x  = {1'b0, sq_q} + {{(ACC_W+1-2*DATA_W){1'b0}}, prod};
        max_d = (SAMPLE_VALID && (empty || DATA_IN > max_q)) ? DATA_IN : max_q;
        min_d = (SAMPLE_VALID && (empty || DATA_IN < min_q)) ? DATA_IN : min_q;
        sum_d = !SAMPLE_VALID ? sum_q : sum_x[ACC_W] ? '1 : sum_x[ACC_W-1:0];
        sq_d  = !SAMPLE_VALID ? sq_q : sq_x[ACC_W] ? '1 : sq_x[ACC_W-1:0];
        cnt_d = (SAMPLE_VALID && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        ovf_d = ovf_q | (SAMPLE_VALID & (sum_x[ACC_W] | sq_x[ACC_W] | (&cnt_q)));
        close = EXT_FRAME ? FRAME_END : (SAMPLE_VALID && cnt_d == WIN);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            MAX_VOL     <= '0;
            MIN_VOL     <= '1;
            PK_PK       <= '0;
            SUM         <= '0;
            SUM_SQ      <= '0;
            SAMPLE_CNT  <= '0;
            OVF         <= 1'b0;
            STATS_VALID <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
            sum_q       <= '0;
            sq_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            STATS_VALID <= close;
            if (close) begin
                MAX_VOL    <= max_d;
                MIN_VOL    <= min_d;
                PK_PK      <= max_d - min_d;
                SUM        <= sum_d;
                SUM_SQ     <= sq_d;
                SAMPLE_CNT <= cnt_d;
                OVF        <= ovf_d;
                max_q      <= '0;
                min_q      <= '0;
                sum_q      <= '0;
                sq_q       <= '0;
                cnt_q      <= '0;
                ovf_q      <= 1'b0;
            end else begin
                max_q <= max_d;
                min_q <= min_d;
                sum_q <= sum_d;
                sq_q  <= sq_d;
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_voltage_stats_block.sv
// tb_voltage_stats_block: directed and random stimulus against a window-list reference model, checked through a result scoreboard.
module tb_voltage_stats_block;
    localparam int DW = 12, AW = 24, CW = 8, WL = 4;
    localparam longint ACC_MAX = (longint'(1) << AW) - 1;
    localparam int CNT_MAX = (1 << CW) - 1;
    typedef struct {
        longint mx, mn, pk, sum, sq, cnt, ovf;
    } exp_t;
    logic clk = 1'b0;
    logic RST = 1'b0, EXT_FRAME = 1'b0, FRAME_END = 1'b0, SAMPLE_VALID = 1'b0;
    logic [DW-1:0] DATA_IN = '0;
    logic [DW-1:0] MAX_VOL, MIN_VOL, PK_PK;
    logic [AW-1:0] SUM, SUM_SQ;
    logic [CW-1:0] SAMPLE_CNT;
    logic OVF, STATS_VALID;
    int checks = 0, errors = 0;
    int win[$];
    exp_t sb[$];
    voltage_stats_block #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .WIN_LEN(WL)) dut (
        .CLK(clk), .RST(RST), .EXT_FRAME(EXT_FRAME), .FRAME_END(FRAME_END),
        .SAMPLE_VALID(SAMPLE_VALID), .DATA_IN(DATA_IN), .MAX_VOL(MAX_VOL),
        .MIN_VOL(MIN_VOL), .PK_PK(PK_PK), .SUM(SUM), .SUM_SQ(SUM_SQ),
        .SAMPLE_CNT(SAMPLE_CNT), .OVF(OVF), .STATS_VALID(STATS_VALID)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic exp_t model();
        exp_t e;
        e.mx = 0; e.mn = 0; e.sum = 0; e.sq = 0;
        foreach (win[i]) begin
            if (i == 0 || win[i] > e.mx) e.mx = win[i];
            if (i == 0 || win[i] < e.mn) e.mn = win[i];
            e.sum += win[i];
            e.sq += longint'(win[i]) * win[i];
        end
        e.pk  = e.mx - e.mn;
        e.ovf = (e.sum > ACC_MAX || e.sq > ACC_MAX || win.size() > CNT_MAX) ? 1 : 0;
        e.sum = e.sum > ACC_MAX ? ACC_MAX : e.sum;
        e.sq  = e.sq > ACC_MAX ? ACC_MAX : e.sq;
        e.cnt = win.size() > CNT_MAX ? CNT_MAX : win.size();
        return e;
    endfunction
    task automatic cyc(input bit r, input bit v, input int d, input bit ext, input bit fe);
        @(negedge clk);
        RST = r; SAMPLE_VALID = v; DATA_IN = DW'(d); EXT_FRAME = ext; FRAME_END = fe;
        @(posedge clk);
        if (r) win.delete();
        else begin
            if (v) win.push_back(d);
            if (ext ? fe : (v && win.size() == WL)) begin
                sb.push_back(model());
                win.delete();
            end
        end
    endtask
    task automatic chk_reset();
        @(negedge clk);
        chk("rst_max", MAX_VOL, 0);
        chk("rst_min", MIN_VOL, (1 << DW) - 1);
        chk("rst_pk", PK_PK, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_sq", SUM_SQ, 0);
        chk("rst_cnt", SAMPLE_CNT, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_valid", STATS_VALID, 0);
    endtask
    always @(negedge clk) begin
        if (STATS_VALID) begin
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("max", MAX_VOL, e.mx);
                chk("min", MIN_VOL, e.mn);
                chk("pk_pk", PK_PK, e.pk);
                chk("sum", SUM, e.sum);
                chk("sum_sq", SUM_SQ, e.sq);
                chk("cnt", SAMPLE_CNT, e.cnt);
                chk("ovf", OVF, e.ovf);
            end
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int seq1[4] = '{100, 300, 50, 200};
        bit ext;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_reset();
        foreach (seq1[i]) cyc(0, 1, seq1[i], 0, 0);
        cyc(0, 0, 0, 0, 0);
        foreach (seq1[i]) begin
            cyc(0, 1, seq1[i], 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        repeat (4) cyc(0, 1, 7, 0, 0);
        cyc(0, 1, 10, 1, 0);
        cyc(0, 1, 20, 1, 0);
        cyc(0, 1, 5, 1, 1);
        cyc(0, 0, 0, 1, 1);
        repeat (2000) cyc(0, 1, 4095, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 0, 1, 1);
        repeat (300) cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 9, 0, 0);
        cyc(0, 1, 11, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_reset();
        repeat (4) cyc(0, 1, 42, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, i, 0, 0);
        for (int i = 3; i >= 0; i--) cyc(0, 1, i, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sb_drained_directed", sb.size(), 0);
        ext = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) ext = ~ext;
            cyc(0, $urandom_range(0, 3) != 0,
                ($urandom_range(0, 3) == 0) ? 4095 : int'($urandom_range(0, 4095)),
                ext, $urandom_range(0, 7) == 0);
        end
        cyc(0, 0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("sb_drained_final", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
